internal_ram_dp: RTL

- Parametrised successor to the 512x32 inferred on-chip RAM used by the ZPU core.
- Port A: read/write with byte-lane write strobes. Port B: read-only, independent address. Both ports have registered outputs and output-valid flags.
- A clear sequencer fills the whole array with a fixed value after reset or on request, and holds off both ports while it runs.
- Sits between the ZPU memory interface (port A) and a debug/DMA reader (port B). Maps onto iCE40 EBR.

---
 rtl/internal_ram_dp.sv | 124 ++++++++++++
 1 files changed

// File: rtl/internal_ram_dp.sv
// Dual-port on-chip word RAM: port A read/write with byte strobes, port B read-only.
// A clear sequencer fills the array with CLEAR_VALUE after reset or on request.
module internal_ram_dp #(
    parameter int                    ADDR_WIDTH     = 9,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter int                    RDW_MODE       = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_en,
    input  logic [DATA_WIDTH/8-1:0]   a_we,
    input  logic [ADDR_WIDTH-1:0]     a_addr,
    input  logic [DATA_WIDTH-1:0]     a_din,
    output logic [DATA_WIDTH-1:0]     a_dout,
    output logic                      a_valid,
    input  logic                      b_en,
    input  logic [ADDR_WIDTH-1:0]     b_addr,
    output logic [DATA_WIDTH-1:0]     b_dout,
    output logic                      b_valid,
    input  logic                      clear_req,
    output logic                      ready,
    output logic                      clear_done,
    output logic                      dbg_state
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Handshake: a_en/b_en are accepted only in a cycle where ready=1; there is
    // no back-pressure, and a_valid/b_valid flag the result one cycle later.
    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    a_acc;
    logic                    a_wr;
    logic                    b_acc;
    logic [DATA_WIDTH-1:0]   a_old;
    logic [DATA_WIDTH-1:0]   b_old;
    logic [DATA_WIDTH-1:0]   a_merged;

    assign a_acc     = ready && a_en && !reset;
    assign a_wr      = a_acc && (|a_we);
    assign b_acc     = ready && b_en && !reset;
    assign a_old     = mem[a_addr];
    assign b_old     = mem[b_addr];
    assign dbg_state = (state == ST_CLEAR);

    always_comb begin
        a_merged = a_old;
        for (int i = 0; i < BYTES; i++) begin
            if (a_we[i]) begin
                a_merged[8*i +: 8] = a_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ready      <= (CLEAR_ON_RESET == 0);
            clr_cnt    <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (&clr_cnt) begin
                        state      <= ST_RUN;
                        ready      <= 1'b1;
                        clear_done <= 1'b1;
                        clr_cnt    <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state   <= ST_CLEAR;
                        ready   <= 1'b0;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Array has no reset; only the clear sequencer or port A writes it.
    always_ff @(posedge clk) begin
        if (!reset && state == ST_CLEAR) begin
            mem[clr_cnt] <= CLEAR_VALUE;
        end else if (a_wr) begin
            for (int i = 0; i < BYTES; i++) begin
                if (a_we[i]) begin
                    mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_dout  <= '0;
            a_valid <= 1'b0;
            b_dout  <= '0;
            b_valid <= 1'b0;
        end else begin
            a_valid <= a_acc;
            b_valid <= b_acc;
            if (a_acc) begin
                a_dout <= (RDW_MODE != 0) ? a_merged : a_old;
            end
            // Write-first collisions hand port B the same merged word port A stores.
            if (b_acc) begin
                b_dout <= (RDW_MODE != 0 && a_wr && a_addr == b_addr) ? a_merged : b_old;
            end
        end
    end

endmodule
